// File: rtl/mem_bus_pkg.sv
// Shared bus widths, latency-counter width and FSM state encoding
// for the core-to-memory bridge.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int CNT_W  = 32;
  // Wide enough for RD_LATENCY up to 7
  localparam int LAT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/mem_axi_bridge.sv
// Single-outstanding bridge from a simple core request port to split
// AR/AW/W/B memory channels with a fixed read-data latency.
module mem_axi_bridge
  import mem_bus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] io_awaddr,
  output logic              io_awvalid,
  input  logic              io_awready,
  output logic [DATA_W-1:0] io_wdata,
  output logic [STRB_W-1:0] io_wstrb,
  output logic              io_wvalid,
  input  logic              io_wready,
  input  logic              io_bvalid,
  output logic [ADDR_W-1:0] io_araddr,
  output logic              io_arvalid,
  input  logic              io_arready,
  input  logic [DATA_W-1:0] io_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  state_e              r_state;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_awvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [CNT_W-1:0]    r_rd_count;
  logic [CNT_W-1:0]    r_wr_count;

  logic w_accept;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_lat_hit;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_ar_hs   = r_arvalid & io_arready;
  assign w_aw_hs   = r_awvalid & io_awready;
  assign w_w_hs    = r_wvalid & io_wready;
  assign w_aw_fin  = r_aw_done | w_aw_hs;
  assign w_w_fin   = r_w_done | w_w_hs;
  // Counter starts at 0 in the first cycle after the AR handshake
  assign w_lat_hit = (r_lat_cnt == LAT_W'(RD_LATENCY - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lat_cnt    <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_wvalid     <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (req_wen) begin
              r_awaddr  <= req_addr;
              r_wdata   <= req_wdata;
              r_wstrb   <= req_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_REQ;
            end else begin
              r_araddr  <= req_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_lat_cnt <= '0;
            r_state   <= ST_RD_WAIT;
          end
        end
        // The resp_valid cycle is still spent here so no request lands on it
        ST_RD_WAIT: begin
          if (r_resp_valid) begin
            r_state <= ST_IDLE;
          end else if (w_lat_hit) begin
            r_resp_rdata <= io_rdata;
            r_resp_valid <= 1'b1;
            r_rd_count   <= r_rd_count + 32'd1;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (r_resp_valid) begin
            r_state <= ST_IDLE;
          end else if (io_bvalid) begin
            r_resp_valid <= 1'b1;
            r_wr_count   <= r_wr_count + 32'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arvalid <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign io_awaddr  = r_awaddr;
  assign io_awvalid = r_awvalid;
  assign io_wdata   = r_wdata;
  assign io_wstrb   = r_wstrb;
  assign io_wvalid  = r_wvalid;
  assign io_araddr  = r_araddr;
  assign io_arvalid = r_arvalid;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule

// File: doc/mem_axi_bridge.md
MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: cycles from AR handshake to valid io_rdata (range 1..7).
REQ-002 SHALL have ports: clock  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high.
REQ-004 SHALL have core-side ports: req_valid in 1 request present; req_addr in 32 byte address; req_wen in 1 1=write, 0=read; req_wdata in 64 write data; req_wstrb in 8 byte enables; req_ready out 1 request accepted this cycle.
REQ-005 SHALL have core-side ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 64 read data (valid with resp_valid on reads).
REQ-006 SHALL have memory-side ports: io_awaddr out 32; io_awvalid out 1; io_awready in 1; io_wdata out 64; io_wstrb out 8; io_wvalid out 1; io_wready in 1; io_bvalid in 1; io_araddr out 32; io_arvalid out 1; io_arready in 1; io_rdata in 64.
REQ-007 SHALL have debug ports: rd_count out 32, wr_count out 32 (completed transactions).

Function
REQ-008 SHALL implement FSM states IDLE, RD_ADDR, RD_WAIT, WR_REQ, WR_RESP.
REQ-009 req_ready SHALL equal (state==IDLE); acceptance occurs when req_valid && req_ready.
REQ-010 On read acceptance SHALL latch req_addr, go RD_ADDR; io_arvalid/io_araddr registered, asserted from next cycle.
REQ-011 In RD_ADDR io_arvalid SHALL stay high, io_araddr stable, until io_arready; then go RD_WAIT with latency counter cleared.
REQ-012 In RD_WAIT SHALL sample io_rdata exactly RD_LATENCY cycles after AR handshake cycle, into resp_rdata, assert resp_valid for one cycle next cycle, return IDLE.
REQ-013 On write acceptance SHALL latch addr/wdata/wstrb, go WR_REQ; io_awvalid and io_wvalid both asserted from next cycle.
REQ-014 In WR_REQ io_awvalid SHALL drop the cycle after io_awready sampled high, io_wvalid the cycle after io_wready sampled high, independently; AW/W may complete in same or different cycles, in either order.
REQ-015 When both AW and W handshakes done SHALL go WR_RESP; io_bvalid ignored before that.
REQ-016 In WR_RESP on io_bvalid SHALL pulse resp_valid next cycle, return IDLE; resp_rdata unchanged on writes.
REQ-017 Address/data outputs SHALL stay stable while corresponding valid high; address passed unmodified (no alignment).
REQ-018 rd_count/wr_count SHALL increment by 1 per completion (on resp_valid), wrap 0xFFFFFFFF->0.
REQ-019 req_ready low in any non-IDLE state; no request accepted same cycle resp_valid pulses (back-to-back requests: min one IDLE cycle).
REQ-020 io_arvalid and io_awvalid/io_wvalid SHALL never be high simultaneously.

Reset
REQ-021 On reset SHALL asynchronously enter IDLE: all valids, resp_valid 0; resp_rdata, addr/data regs, counters 0; req_ready 1 after release.
REQ-022 Reset mid-transaction SHALL abort it with no resp_valid and no counter increment.

Structure
REQ-023 State enum and RD_LATENCY width constant SHALL live in shared package mem_bus_pkg with the 32/64/8 bus widths.
REQ-024 Single module; no sub-module required (latency counter inline).

Verification
REQ-025 Read: addr 0x80000008, arready held 1, RD_LATENCY=1, rdata 0x1122334455667788 -> arvalid 1 cycle, resp_valid at handshake+2 with that data, rd_count=1.
REQ-026 Write: addr 0x80000010, wdata 0xDEADBEEF, wstrb 0x0F; awready/wready same cycle, bvalid 2 cycles later -> resp_valid cycle after bvalid, wr_count=1.
REQ-027 Skewed write: awready 3 cycles before wready -> awvalid drops early, wvalid held, no WR_RESP until wready; bvalid while in WR_REQ ignored.
REQ-028 Stalled read: arready low 5 cycles -> arvalid/araddr stable throughout, req_ready 0, single resp_valid.
REQ-029 Reset asserted during WR_RESP -> immediate IDLE, all valids 0, no resp_valid, counters 0.
REQ-030 RD_LATENCY=3 back-to-back reads -> data sampled 3 cycles post-handshake, one IDLE cycle between transactions.
